profile_folder: RTL

Multi-channel, parametrised phase-folding accumulator for the pulse-timing datapath. It detects rising edges on NCH asynchronous pulse inputs and tracks the fold phase as a bin index with a divider-free fractional accumulator. It increments a per-channel, per-bin counter on every detected pulse. The resulting profiles can be read back at any time through a registered read port, so the block replaces the single-channel pulse/phase/profile chain.

---
 rtl/profile_pkg.sv | 16 +
 rtl/profile_bank.sv | 65 ++++++
 rtl/profile_folder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/profile_pkg.sv
// Shared types and default sizes for the multi-channel phase-folding profiler.
package profile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ARMED = 2'd2,
    FOLD  = 2'd3
  } fold_state_t;

  localparam int NBINS_DEF  = 1024;
  localparam int CNT_W_DEF  = 32;
  localparam int TIME_W_DEF = 32;
  localparam int ROT_W      = 32;

endpackage

// File: rtl/profile_bank.sv
// One channel's profile memory: clear write, read-modify-write increment and
// a registered read-first external read port.
// FOLD_SATURATE_EN: counters stick at all-ones and report a saturation hit.
module profile_bank
  import profile_pkg::*;
#(
  parameter int NBINS = NBINS_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int BIN_W = $clog2(NBINS)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_en_i,
  input  logic [BIN_W-1:0] clr_addr_i,
  input  logic             inc_en_i,
  input  logic [BIN_W-1:0] inc_addr_i,
  input  logic             rd_en_i,
  input  logic [BIN_W-1:0] rd_addr_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             sat_hit_o
);

  logic [CNT_W-1:0] mem [NBINS];
  logic [CNT_W-1:0] rmw_data_q;
  logic [CNT_W-1:0] rd_data_q;
  logic             rmw_pend_q;
  logic [BIN_W-1:0] rmw_addr_q;
  logic [CNT_W-1:0] inc_val;
  logic             sat_hit;

  // track the increment whose old value is being fetched this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rmw_pend_q <= 1'b0;
      rmw_addr_q <= '0;
    end else begin
      rmw_pend_q <= inc_en_i;
      if (inc_en_i) rmw_addr_q <= inc_addr_i;
    end
  end

  // incremented value, held at all-ones when saturation is enabled
  always_comb begin
    inc_val = rmw_data_q + CNT_W'(1);
    sat_hit = 1'b0;
`ifdef FOLD_SATURATE_EN
    if (&rmw_data_q) begin
      inc_val = rmw_data_q;
      sat_hit = rmw_pend_q;
    end
`endif
  end

  // memory: port A clears or completes the increment, port B serves reads (read-first)
  always_ff @(posedge clk) begin
    if (inc_en_i) rmw_data_q <= mem[inc_addr_i];
    if (clr_en_i)        mem[clr_addr_i] <= '0;
    else if (rmw_pend_q) mem[rmw_addr_q] <= inc_val;
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
  assign sat_hit_o = sat_hit;

endmodule

// File: rtl/profile_folder.sv
// Multi-channel phase-folding accumulator: FSM, divider-free fold phase,
// pulse synchronisers/edge detect, per-channel banks and the read mux.
// FOLD_SATURATE_EN: enables saturating counters and the sticky sat flag.
module profile_folder
  import profile_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int NBINS  = NBINS_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TIME_W = TIME_W_DEF,
  localparam int BIN_W = $clog2(NBINS),
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    pulse_in,
  input  logic [TIME_W-1:0] period,
  input  logic [TIME_W-1:0] epoch,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              folding,
  output logic              cfg_err,
  output logic              sat,
  output logic [ROT_W-1:0]  rot_cnt,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [BIN_W-1:0]  rd_addr,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data
);

  fold_state_t       state_q, state_d;
  logic [TIME_W-1:0] wait_q, wait_d;
  logic [TIME_W-1:0] frac_q, frac_d;
  logic [TIME_W-1:0] period_q, period_d;
  logic [TIME_W-1:0] epoch_q, epoch_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [ROT_W-1:0]  rot_q, rot_d;
  logic              cfg_err_q, cfg_err_d;
  logic [TIME_W:0]   frac_sum;
  logic              start_ok;

  logic [NCH-1:0]    sync1_q, sync2_q, sync3_q;
  logic [NCH-1:0]    inc_en;
  logic              rd_valid_q;
  logic [CH_W-1:0]   rd_ch_q;
  logic [CNT_W-1:0]  bank_rd [NCH];

  assign start_ok = (state_q == IDLE) && start && !stop && (period >= TIME_W'(NBINS));
  assign frac_sum = {1'b0, frac_q} + (TIME_W+1)'(NBINS);

  // next-state and fold phase update; wait_q doubles as the clear address
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    frac_d    = frac_q;
    bin_d     = bin_q;
    rot_d     = rot_q;
    cfg_err_d = cfg_err_q;
    period_d  = period_q;
    epoch_d   = epoch_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          period_d = period;
          epoch_d  = epoch;
          if (start_ok) begin
            cfg_err_d = 1'b0;
            rot_d     = '0;
            wait_d    = '0;
            state_d   = CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        CLEAR: if (wait_q == TIME_W'(NBINS-1)) begin
          state_d = ARMED;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + TIME_W'(1);
        end
        ARMED: if (wait_q == epoch_q) begin
          state_d = FOLD;
          bin_d   = '0;
          frac_d  = '0;
        end else begin
          wait_d = wait_q + TIME_W'(1);
        end
        FOLD: if (frac_sum >= {1'b0, period_q}) begin
          frac_d = frac_sum[TIME_W-1:0] - period_q;
          bin_d  = bin_q + BIN_W'(1);
          if (bin_q == BIN_W'(NBINS-1) && rot_q != '1) rot_d = rot_q + ROT_W'(1);
        end else begin
          frac_d = frac_sum[TIME_W-1:0];
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // control and phase registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      frac_q    <= '0;
      bin_q     <= '0;
      rot_q     <= '0;
      cfg_err_q <= 1'b0;
      period_q  <= '0;
      epoch_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      frac_q    <= frac_d;
      bin_q     <= bin_d;
      rot_q     <= rot_d;
      cfg_err_q <= cfg_err_d;
      period_q  <= period_d;
      epoch_q   <= epoch_d;
    end
  end

  // pulse synchronisers, edge history and read-side pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
    end else begin
      sync1_q    <= pulse_in;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      rd_valid_q <= rd_en;
      if (rd_en) rd_ch_q <= rd_ch;
    end
  end

  assign inc_en = sync2_q & ~sync3_q & {NCH{state_q == FOLD}};

`ifdef FOLD_SATURATE_EN
  logic [NCH-1:0] sat_hit;
  logic           sat_q;
  // sticky saturation flag, cleared by an accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          sat_q <= 1'b0;
    else if (start_ok) sat_q <= 1'b0;
    else if (|sat_hit) sat_q <= 1'b1;
  end
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_bank
    profile_bank #(.NBINS(NBINS), .CNT_W(CNT_W)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .clr_en_i   (state_q == CLEAR),
      .clr_addr_i (wait_q[BIN_W-1:0]),
      .inc_en_i   (inc_en[gi]),
      .inc_addr_i (bin_q),
      .rd_en_i    (rd_en),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (bank_rd[gi]),
`ifdef FOLD_SATURATE_EN
      .sat_hit_o  (sat_hit[gi])
`else
      .sat_hit_o  ()
`endif
    );
  end

  assign busy     = (state_q == CLEAR);
  assign folding  = (state_q == FOLD);
  assign cfg_err  = cfg_err_q;
  assign rot_cnt  = rot_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? bank_rd[rd_ch_q] : '0;

endmodule
